// File: rtl/riscv_pkg.sv
// riscv_pkg: shared LSU state encoding, access-size constants and bus-lane helpers.
package riscv_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  function automatic logic [3:0] lsu_be(input logic [1:0] len, input logic [1:0] off);
    return len == MEM_B ? 4'b0001 << off : len == MEM_H ? 4'b0011 << off : 4'b1111;
  endfunction
  function automatic logic [31:0] lsu_wdata(input logic [1:0] len, input logic [31:0] wd);
    return len == MEM_B ? {4{wd[7:0]}} : len == MEM_H ? {2{wd[15:0]}} : wd;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the addressed lane down and sign/zero-extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] data_rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  len,
  input  logic        sign,
  output logic [31:0] result
);
  logic [31:0] s;
  always_comb begin
    s = data_rdata >> {off, 3'b000};
    result = len == MEM_B ? {{24{sign & s[7]}}, s[7:0]} :
             len == MEM_H ? {{16{sign & s[15]}}, s[15:0]} : s;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access FSM over a req/gnt/rvalid bus,
// with load formatting, pipeline stall and misaligned/bus-error reporting.
module load_store_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        L,
  input  logic        wmem,
  input  logic [1:0]  mem_len,
  input  logic        mem_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] rdata_out,
  output logic        misaligned_load,
  output logic        misaligned_store,
  output logic        access_fault,
  output logic [31:0] fault_addr,
  output logic        data_req,
  input  logic        data_gnt,
  output logic [31:0] data_addr,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_wdata,
  input  logic        data_rvalid,
  input  logic [31:0] data_rdata,
  input  logic        data_err
);
  lsu_state_t  state_q, state_d;
  logic [1:0]  len_q, len_d, off_q, off_d;
  logic        sign_q, sign_d, load_q, load_d;
  logic        req_q, req_d, we_q, we_d, done_q, done_d;
  logic [31:0] baddr_q, baddr_d, bwdata_q, bwdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d, faddr_q, faddr_d;
  logic        mld_q, mld_d, mst_q, mst_d, af_q, af_d;
  logic        memop, mis;
  logic [31:0] load_res;
  assign memop = ex_valid & (L | wmem);
  assign mis = (mem_len == MEM_H & addr[0]) | (mem_len[1] & |addr[1:0]);
  lsu_load_align u_align (
    .data_rdata(data_rdata),
    .off(off_q),
    .len(len_q),
    .sign(sign_q),
    .result(load_res)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    off_d = off_q;
    sign_d = sign_q;
    load_d = load_q;
    req_d = req_q;
    we_d = we_q;
    done_d = done_q;
    baddr_d = baddr_q;
    bwdata_d = bwdata_q;
    be_d = be_q;
    rdata_d = rdata_q;
    faddr_d = faddr_q;
    mld_d = mld_q;
    mst_d = mst_q;
    af_d = af_q;
    case (state_q)
      IDLE: if (memop && mis) begin
        mld_d = L;
        mst_d = !L;
        af_d = 1'b0;
        rdata_d = '0;
        faddr_d = addr;
        done_d = 1'b1;
        state_d = DONE;
      end else if (memop) begin
        len_d = mem_len;
        off_d = addr[1:0];
        sign_d = mem_sign;
        load_d = L;
        req_d = 1'b1;
        we_d = !L;
        baddr_d = {addr[31:2], 2'b00};
        be_d = lsu_be(mem_len, addr[1:0]);
        bwdata_d = lsu_wdata(mem_len, wdata);
        state_d = REQ;
      end
      REQ: if (data_gnt) begin
        req_d = 1'b0;
        state_d = RESP;
      end
      RESP: if (data_rvalid) begin
        mld_d = 1'b0;
        mst_d = 1'b0;
        af_d = data_err;
        rdata_d = load_q && !data_err ? load_res : '0;
        faddr_d = data_err ? addr : '0;
        done_d = 1'b1;
        state_d = DONE;
      end
      default: begin
        done_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      off_q <= '0;
      sign_q <= 1'b0;
      load_q <= 1'b0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      baddr_q <= '0;
      bwdata_q <= '0;
      be_q <= '0;
      rdata_q <= '0;
      faddr_q <= '0;
      mld_q <= 1'b0;
      mst_q <= 1'b0;
      af_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      off_q <= off_d;
      sign_q <= sign_d;
      load_q <= load_d;
      req_q <= req_d;
      we_q <= we_d;
      done_q <= done_d;
      baddr_q <= baddr_d;
      bwdata_q <= bwdata_d;
      be_q <= be_d;
      rdata_q <= rdata_d;
      faddr_q <= faddr_d;
      mld_q <= mld_d;
      mst_q <= mst_d;
      af_q <= af_d;
    end
  end
  assign lsu_busy = memop & (state_q != DONE);
  assign lsu_done = done_q;
  assign rdata_out = rdata_q;
  assign misaligned_load = mld_q;
  assign misaligned_store = mst_q;
  assign access_fault = af_q;
  assign fault_addr = faddr_q;
  assign data_req = req_q;
  assign data_addr = baddr_q;
  assign data_we = we_q;
  assign data_be = be_q;
  assign data_wdata = bwdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table, randomized ops against an arithmetic
// reference model, and reset/stray-response sequences.
module tb_load_store_unit;
  logic        clk, rst_n, ex_valid, L, wmem, mem_sign;
  logic [1:0]  mem_len;
  logic [31:0] addr, wdata;
  logic        lsu_busy, lsu_done, misaligned_load, misaligned_store, access_fault;
  logic [31:0] rdata_out, fault_addr;
  logic        data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;
  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .L(L), .wmem(wmem),
    .mem_len(mem_len), .mem_sign(mem_sign), .addr(addr), .wdata(wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .rdata_out(rdata_out),
    .misaligned_load(misaligned_load), .misaligned_store(misaligned_store),
    .access_fault(access_fault), .fault_addr(fault_addr),
    .data_req(data_req), .data_gnt(data_gnt), .data_addr(data_addr),
    .data_we(data_we), .data_be(data_be), .data_wdata(data_wdata),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        l, w;
    logic [1:0]  len;
    logic        sign;
    logic [31:0] a, wd, rd;
    logic        err;
    int          gd, rvd;
    logic [3:0]  be;
    logic [31:0] wdo, rdo;
    logic        ml, ms, af;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    int n, off;
    bit mis;
    longint x;
    vec_t r;
    r = v;
    n = v.len == 2'd0 ? 1 : v.len == 2'd1 ? 2 : 4;
    off = int'(v.a[1:0]);
    mis = (off % n) != 0;
    r.ml = mis && v.l;
    r.ms = mis && !v.l;
    r.af = !mis && v.err;
    r.be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) r.wdo[8*i +: 8] = v.wd[8*(i % n) +: 8];
    x = (longint'(v.rd) >> (8 * off)) % (longint'(1) << (8 * n));
    if (v.sign && n < 4 && x >= (longint'(1) << (8 * n - 1))) x -= longint'(1) << (8 * n);
    r.rdo = (v.l && !mis && !v.err) ? x[31:0] : 32'h0;
    r.lat = mis ? 1 : 3 + v.gd + v.rvd;
    return r;
  endfunction

  task automatic do_op(input vec_t v);
    logic [31:0] c_addr, c_wd, r_rdo, r_fa;
    logic [3:0]  c_be;
    logic        c_we, r_ml, r_ms, r_af;
    bit have, granted, rv_sent, done_seen, busy_ok, req_ok, stab_ok, fault;
    int lat, gcnt, rcnt;
    have = 0; granted = 0; rv_sent = 0; done_seen = 0;
    busy_ok = 1; req_ok = 1; stab_ok = 1;
    lat = 0; gcnt = 0; rcnt = 0;
    c_addr = 0; c_wd = 0; c_be = 0; c_we = 0;
    r_rdo = 0; r_fa = 0; r_ml = 0; r_ms = 0; r_af = 0;
    ex_valid = 1; L = v.l; wmem = v.w; mem_len = v.len; mem_sign = v.sign;
    addr = v.a; wdata = v.wd;
    #1 chk({v.nm, ".busy_accept"}, lsu_busy, 1);
    for (int c = 0; c < 64 && !done_seen; c++) begin
      @(negedge clk);
      lat++;
      if (data_gnt) begin data_gnt = 0; granted = 1; end
      if (data_rvalid) begin data_rvalid = 0; data_err = 0; end
      data_rdata = $urandom;
      if (lsu_done) begin
        done_seen = 1;
        if (lsu_busy) busy_ok = 0;
        r_rdo = rdata_out; r_ml = misaligned_load; r_ms = misaligned_store;
        r_af = access_fault; r_fa = fault_addr;
        ex_valid = 0;
      end else begin
        if (!lsu_busy) busy_ok = 0;
        if (data_req && granted) req_ok = 0;
        if (data_req && !granted) begin
          if (!have) begin
            have = 1; c_addr = data_addr; c_be = data_be; c_we = data_we; c_wd = data_wdata;
          end else if (c_addr !== data_addr || c_be !== data_be || c_we !== data_we || c_wd !== data_wdata)
            stab_ok = 0;
          if (gcnt == v.gd) data_gnt = 1; else gcnt++;
        end
        if (granted && !rv_sent) begin
          if (rcnt == v.rvd) begin
            data_rvalid = 1; data_rdata = v.rd; data_err = v.err; rv_sent = 1;
          end else rcnt++;
        end
      end
    end
    fault = v.ml || v.ms || v.af;
    chk({v.nm, ".done"}, done_seen, 1);
    if (done_seen) begin
      chk({v.nm, ".latency"}, lat, v.lat);
      chk({v.nm, ".busy"}, busy_ok, 1);
      chk({v.nm, ".req_seen"}, have, !(v.ml || v.ms));
      chk({v.nm, ".req_after_gnt"}, req_ok, 1);
      chk({v.nm, ".rdata_out"}, r_rdo, v.rdo);
      chk({v.nm, ".faults"}, {r_ml, r_ms, r_af}, {v.ml, v.ms, v.af});
      if (fault) chk({v.nm, ".fault_addr"}, r_fa, v.a);
      if (have) begin
        chk({v.nm, ".data_addr"}, c_addr, {v.a[31:2], 2'b00});
        chk({v.nm, ".data_be"}, c_be, v.be);
        chk({v.nm, ".data_we"}, c_we, !v.l);
        if (!v.l) chk({v.nm, ".data_wdata"}, c_wd, v.wdo);
        chk({v.nm, ".stable"}, stab_ok, 1);
      end
    end
    @(negedge clk);
    chk({v.nm, ".done_pulse"}, lsu_done, 0);
  endtask

  vec_t tbl[12];
  vec_t rv;
  bit   req_up, stray_ok;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          nm      l  w  len   sg a            wd            rd            err gd rv be       wdo           rdo           ml ms af lat
    tbl[0]  = '{"sw",   0, 1, 2'd2, 0, 32'h100,     32'hDEADBEEF, 32'h0,        0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 0, 0, 3};
    tbl[1]  = '{"lb",   1, 0, 2'd0, 1, 32'h203,     32'h0,        32'h80123456, 0, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 0, 0, 3};
    tbl[2]  = '{"lbu",  1, 0, 2'd0, 0, 32'h203,     32'h0,        32'h80123456, 0, 0, 0, 4'b1000, 32'h0,        32'h00000080, 0, 0, 0, 3};
    tbl[3]  = '{"sh",   0, 1, 2'd1, 0, 32'h102,     32'h00001234, 32'h0,        0, 3, 0, 4'b1100, 32'h12341234, 32'h0,        0, 0, 0, 6};
    tbl[4]  = '{"lw_mis",1,0, 2'd2, 0, 32'h101,     32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 0, 0, 1};
    tbl[5]  = '{"lh_err",1,0, 2'd1, 1, 32'h104,     32'h0,        32'hFFFF8001, 1, 0, 0, 4'b0011, 32'h0,        32'h0,        0, 0, 1, 3};
    tbl[6]  = '{"lhu",  1, 0, 2'd1, 0, 32'h106,     32'h0,        32'h87654321, 0, 1, 2, 4'b1100, 32'h0,        32'h00008765, 0, 0, 0, 6};
    tbl[7]  = '{"lh",   1, 0, 2'd1, 1, 32'h106,     32'h0,        32'h87654321, 0, 0, 1, 4'b1100, 32'h0,        32'hFFFF8765, 0, 0, 0, 4};
    tbl[8]  = '{"sb",   0, 1, 2'd0, 0, 32'h3,       32'h123456AB, 32'h0,        0, 2, 0, 4'b1000, 32'hABABABAB, 32'h0,        0, 0, 0, 5};
    tbl[9]  = '{"sw_mis",0,1, 2'd2, 0, 32'h102,     32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 1, 0, 1};
    tbl[10] = '{"lw_l3",1, 1, 2'd3, 0, 32'h8,       32'hCAFEF00D, 32'h12345678, 0, 0, 0, 4'b1111, 32'h0,        32'h12345678, 0, 0, 0, 3};
    tbl[11] = '{"sh_mis",0,1, 2'd1, 0, 32'hABC1,    32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 1, 0, 1};
    rst_n = 0; ex_valid = 0; L = 0; wmem = 0; mem_len = 0; mem_sign = 0; addr = 0; wdata = 0;
    data_gnt = 0; data_rvalid = 0; data_rdata = 0; data_err = 0;
    repeat (3) @(negedge clk);
    chk("reset.ctrl", {lsu_busy, lsu_done, misaligned_load, misaligned_store, access_fault, data_req, data_we}, 7'h0);
    chk("reset.data", {data_addr, data_be, data_wdata}, 68'h0);
    chk("reset.result", {rdata_out, fault_addr}, 64'h0);
    rst_n = 1;
    @(negedge clk);
    ex_valid = 1; L = 0; wmem = 0;
    #1 chk("nonmem.busy", lsu_busy, 0);
    ex_valid = 0; L = 1;
    #1 chk("novalid.busy", lsu_busy, 0);
    @(negedge clk);
    chk("nonmem.idle", {data_req, lsu_done}, 2'b00);
    L = 0;
    foreach (tbl[i]) do_op(tbl[i]);
    for (int i = 0; i < 40; i++) begin
      rv.nm = $sformatf("rnd%0d", i);
      rv.l = 1'($urandom); rv.w = rv.l ? 1'($urandom) : 1'b1;
      rv.len = 2'($urandom_range(0, 3)); rv.sign = 1'($urandom);
      rv.a = $urandom;
      if ($urandom_range(0, 9) < 7) rv.a = rv.len == 2'd0 ? rv.a : rv.len == 2'd1 ? rv.a & ~32'h1 : rv.a & ~32'h3;
      rv.wd = $urandom; rv.rd = $urandom; rv.err = ($urandom_range(0, 7) == 0);
      rv.gd = $urandom_range(0, 3); rv.rvd = $urandom_range(0, 3);
      do_op(model(rv));
    end
    // Reset while waiting for the response, then a stray rvalid must be ignored.
    ex_valid = 1; L = 1; wmem = 0; mem_len = 2'd2; mem_sign = 0; addr = 32'h200;
    req_up = 0;
    for (int c = 0; c < 10 && !req_up; c++) begin @(negedge clk); req_up = data_req; end
    chk("rst_resp.req_up", req_up, 1);
    data_gnt = 1;
    @(negedge clk);
    data_gnt = 0;
    rst_n = 0; ex_valid = 0;
    @(negedge clk);
    chk("rst_resp.req", data_req, 0);
    chk("rst_resp.regs", {data_addr, data_be, rdata_out}, 68'h0);
    rst_n = 1;
    @(negedge clk);
    data_rvalid = 1; data_rdata = 32'h55AA55AA;
    @(negedge clk);
    data_rvalid = 0;
    stray_ok = 1;
    repeat (3) begin @(negedge clk); if (lsu_done || data_req) stray_ok = 0; end
    chk("rst_resp.stray", stray_ok, 1);
    // Reset while still requesting: the request must drop on the next edge.
    ex_valid = 1; L = 0; wmem = 1; mem_len = 2'd2; addr = 32'h40; wdata = 32'h1;
    req_up = 0;
    for (int c = 0; c < 10 && !req_up; c++) begin @(negedge clk); req_up = data_req; end
    chk("rst_req.req_up", req_up, 1);
    rst_n = 0; ex_valid = 0;
    @(negedge clk);
    chk("rst_req.req", data_req, 0);
    rst_n = 1;
    @(negedge clk);
    do_op(tbl[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
